// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity-sense constants and parameter range checks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Plain constants so the FSM register can stay a simple logic vector.
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    localparam int UART_PARITY_EVEN = 0;
    localparam int UART_PARITY_ODD  = 1;

    function automatic bit uart_data_bits_ok(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

    function automatic bit uart_clks_per_bit_ok(input int n);
        return n >= 2;
    endfunction

    function automatic bit uart_stop_bits_ok(input int n);
        return (n == 1) || (n == 2);
    endfunction

    function automatic bit uart_parity_ok(input int n);
        return (n == UART_PARITY_EVEN) || (n == UART_PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last clock of
// each serial bit. Held at zero while clear is high so every bit period
// starts from a fresh count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = (cnt_q == CNT_LAST);

    // Next count: hold at zero when cleared, wrap at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional
// parity bit, STOP_BITS stop bits, each held CLKS_PER_BIT clocks.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 DataValid,
    output logic                 DataReady,
    input  logic [DATA_BITS-1:0] DataIN,
    output logic                 tx,
    output logic                 Busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit PARAMS_OK = uart_data_bits_ok(DATA_BITS)
                            && uart_clks_per_bit_ok(CLKS_PER_BIT)
                            && uart_stop_bits_ok(STOP_BITS)
                            && uart_parity_ok(PARITY_ODD);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign DataReady = (state_q == ST_IDLE) && !Reset;
    assign accept    = DataValid && DataReady;
    assign tx        = tx_q;
    assign Busy      = busy_q;

    // Timer is parked at zero while idle; all other transitions land on a wrap.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (state_q == ST_IDLE),
        .bit_done(bit_done)
    );

    // Frame sequencer: next state, shift register and the next line level.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = ST_START;
                    shift_d    = DataIN;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the word as latched, before shifting.
                    parity_d   = (^DataIN) ^ (PARITY_ODD == UART_PARITY_ODD);
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset abandons any frame and returns the line high.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Flag an out-of-range parameter set in simulation.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            assert (PARAMS_OK);
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame (DATA_BITS=8, CLKS_PER_BIT=4,
// STOP_BITS=1). With UART_TX_PARITY_EN a second instance with odd parity
// runs on the same inputs.
module tb_uart_tx_frame;

    localparam int DB   = 8;
    localparam int CPB  = 4;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_CLKS = (1 + DB + P + SB) * CPB;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          DataValid = 1'b0;
    logic [DB-1:0] DataIN = '0;
    logic          DataReady;
    logic          tx;
    logic          Busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_frame_len;
    logic last_parity;
    logic last_parity2;

    uart_tx_frame #(
        .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .CLK(CLK), .Reset(Reset), .DataValid(DataValid), .DataReady(DataReady),
        .DataIN(DataIN), .tx(tx), .Busy(Busy)
    );

`ifdef UART_TX_PARITY_EN
    logic DataReady_o, tx_o, Busy_o;
    uart_tx_frame #(
        .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(1)
    ) dut_odd (
        .CLK(CLK), .Reset(Reset), .DataValid(DataValid), .DataReady(DataReady_o),
        .DataIN(DataIN), .tx(tx_o), .Busy(Busy_o)
    );
`endif

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected line level c clocks after the start bit began, derived from
    // the frame layout: bit slot = c / CPB.
    function automatic logic exp_bit(input logic [DB-1:0] w, input int c, input int odd);
        int b;
        int ones;
        b = c / CPB;
        ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(w[i]);
        if (b == 0) return 1'b0;
        if (b <= DB) return w[b-1];
        if (P == 1 && b == DB + 1) return (odd != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (DataReady !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (DataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_timeout: DataReady=%b required=1", name, DataReady);
        end
    endtask

    // Hand one word over (DataReady must already be high), then watch the
    // whole frame cycle by cycle against the model and decode it mid-bit.
    task automatic run_frame(input logic [DB-1:0] w, input int poke_at,
                             input bit keep_valid, input logic [DB-1:0] next_w,
                             input string name);
        int wave_err, wave2_err, ctl_err, first_bad, busy_cnt;
        logic first_act, first_exp;
        logic [DB-1:0] dec;
        wave_err = 0; wave2_err = 0; ctl_err = 0; first_bad = -1; busy_cnt = 0;
        first_act = 1'b0; first_exp = 1'b0; dec = '0;
        DataIN = w;
        DataValid = 1'b1;
        n_cmp++;
        if (DataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: DataReady=%b required=1", name, DataReady);
        end
        tick();
        if (keep_valid) DataIN = next_w;
        else begin
            DataValid = 1'b0;
            DataIN = DB'($urandom);
        end
        for (int c = 0; c < FRAME_CLKS; c++) begin
            if (tx !== exp_bit(w, c, PODD)) begin
                if (first_bad < 0) begin
                    first_bad = c; first_act = tx; first_exp = exp_bit(w, c, PODD);
                end
                wave_err++;
            end
`ifdef UART_TX_PARITY_EN
            if (tx_o !== exp_bit(w, c, 1)) wave2_err++;
            if (c / CPB == DB + 1 && c % CPB == CPB / 2) begin
                last_parity = tx;
                last_parity2 = tx_o;
            end
`endif
            if (Busy === 1'b1) busy_cnt++;
            if (Busy !== 1'b1 || DataReady !== 1'b0) ctl_err++;
            if (c % CPB == CPB / 2 && c / CPB >= 1 && c / CPB <= DB) dec[c/CPB-1] = tx;
            if (c == poke_at) begin
                DataValid = 1'b1;
                DataIN = '1;
            end else if (c == poke_at + 1) begin
                DataValid = 1'b0;
                DataIN = DB'($urandom);
            end
            tick();
        end
        last_frame_len = busy_cnt;
        n_cmp++;
        if (wave_err != 0) begin
            n_fail++;
            $display("FAIL %s wave: word=%h %0d bad clocks, first at %0d tx=%b required=%b",
                     name, w, wave_err, first_bad, first_act, first_exp);
        end
`ifdef UART_TX_PARITY_EN
        n_cmp++;
        if (wave2_err != 0) begin
            n_fail++;
            $display("FAIL %s wave_odd: word=%h %0d bad clocks, required 0", name, w, wave2_err);
        end
`endif
        n_cmp++;
        if (ctl_err != 0) begin
            n_fail++;
            $display("FAIL %s busy_ready: %0d bad clocks, required 0", name, ctl_err);
        end
        n_cmp++;
        if (dec !== w) begin
            n_fail++;
            $display("FAIL %s decode: got=%h required=%h", name, dec, w);
        end
        n_cmp++;
        if (DataReady !== 1'b1 || Busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end_of_frame: ready=%b busy=%b tx=%b required 1/0/1",
                     name, DataReady, Busy, tx);
        end
        $display("frame %s: word=%h decoded=%h busy_clocks=%0d", name, w, dec, busy_cnt);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        DataValid = 1'b1;
        DataIN = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (tx !== 1'b1 || Busy !== 1'b0 || DataReady !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: tx=%b busy=%b ready=%b required 1/0/0", tx, Busy, DataReady);
            end
        end
        Reset = 1'b0;
        DataValid = 1'b0;
        #1;
        n_cmp++;
        if (DataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: DataReady=%b required=1", DataReady);
        end
        tick();
        n_cmp++;
        if (Busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_transfer: busy=%b tx=%b required 0/1", Busy, tx);
        end
        $display("reset: ready=%b busy=%b tx=%b", DataReady, Busy, tx);
    endtask

    task automatic test_single_frame();
        wait_ready("single");
        run_frame(8'h55, -10, 1'b0, '0, "single");
        n_cmp++;
        if (last_frame_len != FRAME_CLKS) begin
            n_fail++;
            $display("FAIL single_len: busy clocks=%0d required=%0d", last_frame_len, FRAME_CLKS);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 6; i++) begin
            wait_ready("random");
            run_frame(DB'($urandom), -10, 1'b0, '0, "random");
        end
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b");
        run_frame(8'hA3, -10, 1'b1, 8'h0F, "b2b_first");
        run_frame(8'h0F, -10, 1'b0, '0, "b2b_second");
    endtask

    task automatic test_busy_ignore();
        int extra;
        extra = 0;
        wait_ready("busy");
        run_frame(8'h5A, 13, 1'b0, '0, "busy_poke");
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            if (tx !== 1'b1 || Busy !== 1'b0) extra++;
            tick();
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL busy_no_extra_frame: %0d active clocks, required 0", extra);
        end
        $display("busy: idle check active clocks=%0d", extra);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        wait_ready("parity");
        run_frame(8'h07, -10, 1'b0, '0, "parity");
        n_cmp++;
        if (last_parity !== 1'b1 || last_parity2 !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bit: even=%b odd=%b required 1/0", last_parity, last_parity2);
        end
        n_cmp++;
        if (last_frame_len != 44) begin
            n_fail++;
            $display("FAIL parity_len: busy clocks=%0d required=44", last_frame_len);
        end
    endtask
`endif

    task automatic test_mid_frame_reset();
        logic [DB-1:0] w;
        w = DB'($urandom);
        wait_ready("midreset");
        DataIN = w;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        for (int c = 0; c < 4 + 3 * CPB + 1; c++) tick();
        n_cmp++;
        if (tx !== w[3]) begin
            n_fail++;
            $display("FAIL midreset_bit3: tx=%b required=%b", tx, w[3]);
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (DataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ready: DataReady=%b required=0", DataReady);
        end
        tick();
        n_cmp++;
        if (tx !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: tx=%b busy=%b required 1/0", tx, Busy);
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (DataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_release: DataReady=%b required=1", DataReady);
        end
        $display("midreset: word=%h abandoned, tx=%b busy=%b", w, tx, Busy);
        run_frame(8'h3C, -10, 1'b0, '0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_busy_ignore();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
